// File: rtl/rw_responder_if.sv
// Request/response bundle for rw_responder.
// Optional rsp_par signal present only when RW_RESPONDER_PARITY_EN is defined.
interface rw_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
`ifdef RW_RESPONDER_PARITY_EN
  logic              rsp_par;
`endif

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
`ifdef RW_RESPONDER_PARITY_EN
    , input rsp_par
`endif
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
`ifdef RW_RESPONDER_PARITY_EN
    , output rsp_par
`endif
  );
endinterface

// File: rtl/rw_responder.sv
// rw_responder: single-outstanding write/read target with a small register file.
// Optional feature: RW_RESPONDER_PARITY_EN adds per-register parity storage,
// a parity check on read (mismatch raises rsp_err) and the rsp_par output.
module rw_responder #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 6,
  parameter int RD_LAT   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  rw_responder_if.slave  bus
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
`ifdef RW_RESPONDER_PARITY_EN
  logic [NUM_REGS-1:0] par_q, par_d;
`endif

  // Per-register write strobe: only a non-errored WRITE cycle updates storage.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hit
      assign wr_hit[gi] = (state_q == WRITE) && !err_q && (addr_q == ADDR_W'(gi));
    end
  endgenerate

  // Next register-file contents (and stored parity when enabled).
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
`ifdef RW_RESPONDER_PARITY_EN
      par_d[i]  = par_q[i];
`endif
      if (wr_hit[i]) begin
        regs_d[i] = wdata_q;
`ifdef RW_RESPONDER_PARITY_EN
        par_d[i]  = ^wdata_q;
`endif
      end
    end
  end

  // Request/response FSM: next state and captured request fields.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          err_d   = ({1'b0, bus.req_addr} >= NUM_REGS_W);
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = bus.req_write ? WRITE : READ_WAIT;
        end
      end
      WRITE: begin
        rdata_d = '0;
        state_d = RESP;
      end
      READ_WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rdata_d = err_q ? '0 : regs_q[addr_q];
`ifdef RW_RESPONDER_PARITY_EN
          // Stored parity disagreeing with the data turns the read into an error.
          if (!err_q && (par_q[addr_q] != ^regs_q[addr_q])) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and storage registers; reset discards any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef RW_RESPONDER_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
`ifdef RW_RESPONDER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Response outputs are forced to zero outside RESP; ready is held low during reset.
  assign bus.req_ready = rst_n & (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign bus.rsp_err   = (state_q == RESP) & err_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef RW_RESPONDER_PARITY_EN
  assign bus.rsp_par   = (state_q == RESP) & (^rdata_q);
`endif

endmodule
